serial_add_ctrl: RTL and testbench

Bit-serial multi-bit adder controller. It sequences a single one-bit add slice, built from two `half_adder` instances plus a carry flip-flop, over a WIDTH-bit operand pair, LSB first. The block provides a start/ready/done handshake so an N-bit add reuses one bit of adder hardware across N cycles. It sits between a requesting control unit and the existing half-adder datapath.

---
 rtl/serial_add_pkg.sv | 5 +
 rtl/half_adder.sv | 10 +
 rtl/serial_add_slice.sv | 13 +
 rtl/serial_add_ctrl.sv | 93 +++++++++
 tb/tb_serial_add_ctrl.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/serial_add_pkg.sv
// serial_add_pkg: shared FSM state type and default operand width for the serial adder
package serial_add_pkg;
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   localparam int SA_WIDTH_DEF = 8;
endpackage

// File: rtl/half_adder.sv
// half_adder: one-bit half adder (sum = a ^ b, carry = a & b)
module half_adder (
   input  logic a_i,
   input  logic b_i,
   output logic s_o,
   output logic c_o
);
   assign s_o = a_i ^ b_i;
   assign c_o = a_i & b_i;
endmodule

// File: rtl/serial_add_slice.sv
// serial_add_slice: combinational one-bit full-add slice from two half adders and an OR
module serial_add_slice (
   input  logic a_i,
   input  logic b_i,
   input  logic c_i,
   output logic s_o,
   output logic c_o
);
   logic s1, c1, c2;
   half_adder u_ha0 (.a_i(a_i), .b_i(b_i), .s_o(s1), .c_o(c1));
   half_adder u_ha1 (.a_i(s1), .b_i(c_i), .s_o(s_o), .c_o(c2));
   assign c_o = c1 | c2;
endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial WIDTH-bit adder, LSB first, start/ready/done handshake; OVF port with SERIAL_ADD_OVF_EN
module serial_add_ctrl
   import serial_add_pkg::*;
#(
   parameter int WIDTH = SA_WIDTH_DEF
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             ready_o,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] sum_o,
   output logic             cout_o
`ifdef SERIAL_ADD_OVF_EN
   ,
   output logic             ovf_o
`endif
);
   localparam int CW = $clog2(WIDTH);
   state_t           state_q;
   logic [WIDTH-1:0] a_q, b_q, sum_q;
   logic [CW-1:0]    cnt_q;
   logic             carry_q, cout_q, ready_q, busy_q, done_q;
   logic             sum_d, carry_d, last;
   assign last = cnt_q == CW'(WIDTH - 1);
   serial_add_slice u_slice (
      .a_i(a_q[0]), .b_i(b_q[0]), .c_i(carry_q), .s_o(sum_d), .c_o(carry_d)
   );
   // FSM, operand/sum shift registers, counter and carry flop with registered handshake outputs
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         ready_q <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: if (start_i) begin
               state_q <= SHIFT;
               a_q     <= a_i;
               b_q     <= b_i;
               sum_q   <= '0;
               cnt_q   <= '0;
               carry_q <= 1'b0;
               ready_q <= 1'b0;
               busy_q  <= 1'b1;
            end
            SHIFT: begin
               sum_q   <= {sum_d, sum_q[WIDTH-1:1]};
               carry_q <= carry_d;
               a_q     <= a_q >> 1;
               b_q     <= b_q >> 1;
               cnt_q   <= last ? '0 : cnt_q + 1'b1;
               if (last) begin
                  state_q <= DONE;
                  cout_q  <= carry_d;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
               done_q  <= 1'b0;
               ready_q <= 1'b1;
            end
         endcase
      end
   end
   assign ready_o = ready_q;
   assign busy_o  = busy_q;
   assign done_o  = done_q;
   assign sum_o   = sum_q;
   assign cout_o  = cout_q;
`ifdef SERIAL_ADD_OVF_EN
   logic ovf_q;
   // signed overflow = carry into MSB xor carry out of MSB, taken on the final bit
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) ovf_q <= 1'b0;
      else if (state_q == IDLE && start_i) ovf_q <= 1'b0;
      else if (state_q == SHIFT && last) ovf_q <= carry_q ^ carry_d;
   end
   assign ovf_o = ovf_q;
`endif
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: table, hand-sequence and random checks of serial_add_ctrl against plain arithmetic
module tb_serial_add_ctrl;
   logic       clk = 1'b0, rst_i = 1'b1, start_i = 1'b0;
   logic [7:0] a_i = '0, b_i = '0, sum_o;
   logic       ready_o, busy_o, done_o, cout_o;
   int         checks = 0, errors = 0;
`ifdef SERIAL_ADD_OVF_EN
   logic ovf_o;
`endif

   serial_add_ctrl #(.WIDTH(8)) dut (
      .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .a_i(a_i), .b_i(b_i),
      .ready_o(ready_o), .busy_o(busy_o), .done_o(done_o), .sum_o(sum_o), .cout_o(cout_o)
`ifdef SERIAL_ADD_OVF_EN
      , .ovf_o(ovf_o)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] a, b, s;
      logic       c, o;
   } vec_t;

   task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", n, got, exp);
      end
   endtask

   task automatic run_add(input string n, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] es, input logic ec, input logic eo);
      int busy_n = 0, done_n = 0, done_at = 0;
      chk({n, " ready before"}, 32'(ready_o), 1);
      a_i = a; b_i = b; start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         if (busy_o) busy_n++;
         if (done_o) begin
            done_n++;
            if (done_at == 0) begin
               done_at = c;
               chk({n, " sum"}, 32'(sum_o), 32'(es));
               chk({n, " cout"}, 32'(cout_o), 32'(ec));
`ifdef SERIAL_ADD_OVF_EN
               chk({n, " ovf"}, 32'(ovf_o), 32'(eo));
`else
               if (eo === 1'bx) $display("note: unknown ovf expectation in %s", n);
`endif
            end
         end
         if (ready_o) break;
         @(negedge clk);
      end
      chk({n, " busy cycles"}, 32'(busy_n), 8);
      chk({n, " done cycles"}, 32'(done_n), 1);
      chk({n, " done latency"}, 32'(done_at), 9);
      chk({n, " ready back"}, 32'(ready_o), 1);
      chk({n, " sum held"}, 32'(sum_o), 32'(es));
   endtask

   task automatic wait_done(input string n);
      bit ok = 0;
      for (int i = 0; i < 30; i++) begin
         if (done_o) begin
            ok = 1;
            break;
         end
         @(negedge clk);
      end
      chk({n, " done seen"}, 32'(ok), 1);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vt[8];
      int   dn;
      vt[0] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
      vt[1] = '{8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
      vt[2] = '{8'hA5, 8'h5A, 8'hFF, 1'b0, 1'b0};
      vt[3] = '{8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
      vt[4] = '{8'hFF, 8'hFF, 8'hFE, 1'b1, 1'b0};
      vt[5] = '{8'h80, 8'h80, 8'h00, 1'b1, 1'b1};
      vt[6] = '{8'h55, 8'hAA, 8'hFF, 1'b0, 1'b0};
      vt[7] = '{8'h01, 8'h02, 8'h03, 1'b0, 1'b0};

      repeat (2) @(negedge clk);
      chk("reset ready", 32'(ready_o), 1);
      chk("reset busy", 32'(busy_o), 0);
      chk("reset done", 32'(done_o), 0);
      chk("reset sum", 32'(sum_o), 0);
      chk("reset cout", 32'(cout_o), 0);
`ifdef SERIAL_ADD_OVF_EN
      chk("reset ovf", 32'(ovf_o), 0);
`endif
      rst_i = 1'b0;
      @(negedge clk);
      chk("idle ready", 32'(ready_o), 1);

      for (int i = 0; i < 8; i++)
         run_add($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].s, vt[i].c, vt[i].o);

      // START held high through a running add and its DONE cycle
      a_i = 8'hA5; b_i = 8'h5A; start_i = 1'b1;
      @(negedge clk);
      a_i = 8'h01; b_i = 8'h02;
      wait_done("hold first");
      chk("hold first sum", 32'(sum_o), 32'hFF);
      chk("hold first cout", 32'(cout_o), 0);
      @(negedge clk);
      chk("hold idle ready", 32'(ready_o), 1);
      chk("hold idle busy", 32'(busy_o), 0);
      @(negedge clk);
      chk("hold accepted busy", 32'(busy_o), 1);
      chk("hold accepted ready", 32'(ready_o), 0);
      start_i = 1'b0;
      wait_done("hold second");
      chk("hold second sum", 32'(sum_o), 32'h03);
      @(negedge clk);

      // START pulse mid-SHIFT with new operands is ignored
      a_i = 8'h10; b_i = 8'h20; start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      repeat (3) @(negedge clk);
      a_i = 8'hFF; start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      chk("ignore busy", 32'(busy_o), 1);
      wait_done("ignore");
      chk("ignore sum", 32'(sum_o), 32'h30);
      chk("ignore cout", 32'(cout_o), 0);
      @(negedge clk);

      // asynchronous reset after four SHIFT edges aborts the add
      a_i = 8'hFF; b_i = 8'hFF; start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      repeat (4) @(negedge clk);
      chk("abort partial sum", 32'(sum_o), 32'hE0);
      rst_i = 1'b1;
      #1;
      chk("abort ready", 32'(ready_o), 1);
      chk("abort busy", 32'(busy_o), 0);
      chk("abort done", 32'(done_o), 0);
      chk("abort sum", 32'(sum_o), 0);
      chk("abort cout", 32'(cout_o), 0);
      @(negedge clk);
      rst_i = 1'b0;
      dn = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (done_o) dn++;
      end
      chk("abort no done", 32'(dn), 0);
      run_add("after abort", 8'h03, 8'h04, 8'h07, 1'b0, 1'b0);

      for (int i = 0; i < 40; i++) begin
         logic [7:0] ra, rb;
         logic [8:0] full;
         ra = 8'($urandom);
         rb = 8'($urandom);
         full = {1'b0, ra} + {1'b0, rb};
         run_add($sformatf("rand%0d %0h+%0h", i, ra, rb), ra, rb, full[7:0], full[8],
                 (ra[7] == rb[7]) && (full[7] != ra[7]));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
